// File: rtl/reg_pair_loader.sv
// Fills an 8-bit register pair from the byte-wide memory bus: one read (byte modes) or two (word mode), then a one-cycle write strobe.
// Optional build macro REG_PAIR_LOADER_TIMEOUT_EN adds a per-byte mem_ready timeout that aborts with an err pulse.
module reg_pair_loader #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [7:0]        mem_data,
    output logic              cs_l_in,
    output logic              cs_h_in,
    output logic              cs_16_in,
    output logic [7:0]        bus_8_in,
    output logic [15:0]       bus_16_in,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, COMMIT} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        mode_reg;
    logic [7:0]        lo_reg;

`ifdef REG_PAIR_LOADER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             wait_expired;
    assign wait_expired = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            mode_reg  <= '0;
            lo_reg    <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            cs_l_in   <= 1'b0;
            cs_h_in   <= 1'b0;
            cs_16_in  <= 1'b0;
            bus_8_in  <= '0;
            bus_16_in <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REG_PAIR_LOADER_TIMEOUT_EN
            wait_cnt_reg <= '0;
            err          <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; data buses keep their last value.
            cs_l_in  <= 1'b0;
            cs_h_in  <= 1'b0;
            cs_16_in <= 1'b0;
            done     <= 1'b0;
`ifdef REG_PAIR_LOADER_TIMEOUT_EN
            err      <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg  <= addr;
                        mode_reg  <= mode;
                        mem_addr  <= addr;
                        mem_rd    <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= RD_LO;
`ifdef REG_PAIR_LOADER_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                    end
                end
                RD_LO: begin
                    if (mem_ready) begin
                        lo_reg <= mem_data;
`ifdef REG_PAIR_LOADER_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                        if (mode_reg[1]) begin
                            // mem_rd stays high; only the address advances (wraps at 2^ADDR_W).
                            mem_addr  <= addr_reg + ADDR_W'(1);
                            state_reg <= RD_HI;
                        end else begin
                            mem_rd    <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cs_l_in   <= ~mode_reg[0];
                            cs_h_in   <= mode_reg[0];
                            bus_8_in  <= mem_data;
                            state_reg <= COMMIT;
                        end
                    end
`ifdef REG_PAIR_LOADER_TIMEOUT_EN
                    else if (wait_expired) begin
                        mem_rd       <= 1'b0;
                        busy         <= 1'b0;
                        err          <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
`endif
                end
                RD_HI: begin
                    if (mem_ready) begin
                        mem_rd    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cs_16_in  <= 1'b1;
                        bus_16_in <= {mem_data, lo_reg};
                        state_reg <= COMMIT;
`ifdef REG_PAIR_LOADER_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                    end
`ifdef REG_PAIR_LOADER_TIMEOUT_EN
                    else if (wait_expired) begin
                        mem_rd       <= 1'b0;
                        busy         <= 1'b0;
                        err          <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
`endif
                end
                COMMIT: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_pair_loader.sv
// Directed bench for reg_pair_loader: vector table of single transfers plus hand-written reset, re-start, back-to-back and timeout sequences.
module tb_reg_pair_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] addr = 16'h0000;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        cs_l_in, cs_h_in, cs_16_in;
    logic [7:0]  bus_8_in;
    logic [15:0] bus_16_in;
    logic        busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    reg_pair_loader #(.ADDR_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .addr(addr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_data(mem_data),
        .cs_l_in(cs_l_in), .cs_h_in(cs_h_in), .cs_16_in(cs_16_in),
        .bus_8_in(bus_8_in), .bus_16_in(bus_16_in),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] addr;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          waits;
        logic [15:0] hi_addr;
        logic [2:0]  cs;      // {cs_16_in, cs_h_in, cs_l_in}
        logic [7:0]  bus8;
        logic [15:0] bus16;
        int          commit;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    function automatic logic [63:0] all_outputs();
        return {17'd0, mem_rd, cs_l_in, cs_h_in, cs_16_in, busy, done, err,
                mem_addr, bus_8_in, bus_16_in};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  n_rd;
        int  n_acc;
        bit  found;
        n_rd = 0; n_acc = 0; found = 0;
        @(negedge clk);
        start = 1'b1; mode = v.mode; addr = v.addr; mem_ready = 1'b0;
        for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cs_l_in || cs_h_in || cs_16_in || done) begin
                found = 1;
                check("commit_cycle", 64'(cyc), 64'(v.commit));
                check("cs_select", 64'({cs_16_in, cs_h_in, cs_l_in}), 64'(v.cs));
                check("done_pulse", 64'(done), 64'd1);
                check("busy_at_commit", 64'(busy), 64'd0);
                check("mem_rd_at_commit", 64'(mem_rd), 64'd0);
                check("bus_8_in", 64'(bus_8_in), 64'(v.bus8));
                check("bus_16_in", 64'(bus_16_in), 64'(v.bus16));
                $display("txn %0d: mode=%b addr=%h commit_cycle=%0d cs=%b bus8=%h bus16=%h",
                         idx, v.mode, v.addr, cyc, {cs_16_in, cs_h_in, cs_l_in}, bus_8_in, bus_16_in);
                mem_ready = 1'b0;
            end else if (mem_rd) begin
                check("mem_addr_during_read", 64'(mem_addr), 64'((n_acc == 0) ? v.addr : v.hi_addr));
                check("busy_during_read", 64'(busy), 64'd1);
                mem_ready = (n_rd >= v.waits);
                mem_data  = (n_acc == 0) ? v.lo : v.hi;
                n_rd++;
                if (mem_ready) n_acc++;
            end else begin
                mem_ready = 1'b0;
            end
        end
        if (!found) bound_fail("commit_wait");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int commits [3];
        int n_commit;
        bit saw_bad;
        int err_cycle;

        //          mode   addr      lo     hi    w  hi_addr   cs      bus8   bus16     commit
        vecs[0] = '{2'b00, 16'h1234, 8'hA5, 8'h00, 0, 16'h0000, 3'b001, 8'hA5, 16'h0000, 2};
        vecs[1] = '{2'b10, 16'hFFFF, 8'h11, 8'h22, 0, 16'h0000, 3'b100, 8'hA5, 16'h2211, 3};
        vecs[2] = '{2'b01, 16'h4000, 8'h5C, 8'h00, 3, 16'h0000, 3'b010, 8'h5C, 16'h2211, 5};
        vecs[3] = '{2'b11, 16'h0100, 8'h34, 8'h12, 1, 16'h0101, 3'b100, 8'h5C, 16'h1234, 4};
        vecs[4] = '{2'b00, 16'h0000, 8'hFF, 8'h00, 0, 16'h0000, 3'b001, 8'hFF, 16'h1234, 2};

        // Reset state
        #2;
        check("reset_outputs", all_outputs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", all_outputs(), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // start re-pulsed during RD_LO is ignored: exactly one done
        @(negedge clk);
        start = 1'b1; mode = 2'b00; addr = 16'h2000; mem_data = 8'h3C; mem_ready = 1'b0;
        n_done = 0; n_commit = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start = (cyc == 1);
            if (done) begin n_done++; n_commit = cyc; end
            mem_ready = (cyc == 3);
        end
        check("repulse_done_count", 64'(n_done), 64'd1);
        check("repulse_commit_cycle", 64'(n_commit), 64'd4);
        $display("txn repulse: done_count=%0d commit_cycle=%0d", n_done, n_commit);

        // Back-to-back word transfers with start held high: commits 4 cycles apart
        @(negedge clk);
        start = 1'b1; mode = 2'b10; addr = 16'h0800; mem_data = 8'h77; mem_ready = 1'b1;
        n_commit = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cs_16_in && n_commit < 3) begin
                commits[n_commit] = cyc;
                n_commit++;
            end
        end
        start = 1'b0; mem_ready = 1'b0;
        check("b2b_commit_count", 64'(n_commit), 64'd3);
        if (n_commit == 3) begin
            check("b2b_first_commit", 64'(commits[0]), 64'd3);
            check("b2b_second_commit", 64'(commits[1]), 64'd7);
            check("b2b_third_commit", 64'(commits[2]), 64'd11);
        end
        check("b2b_bus_16_in", 64'(bus_16_in), 64'h7777);
        $display("txn back_to_back: commits=%0d bus16=%h", n_commit, bus_16_in);
        @(negedge clk);
        @(negedge clk);

        // mem_ready never arrives
        @(negedge clk);
        start = 1'b1; mode = 2'b10; addr = 16'h5555; mem_ready = 1'b0;
        saw_bad = 0; err_cycle = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cs_l_in || cs_h_in || cs_16_in || done) saw_bad = 1;
            if (err) begin
                if (err_cycle != 0) saw_bad = 1;
                else err_cycle = cyc;
            end
        end
        check("stall_no_commit", 64'(saw_bad), 64'd0);
`ifdef REG_PAIR_LOADER_TIMEOUT_EN
        check("timeout_err_cycle", 64'(err_cycle), 64'd16);
        check("timeout_busy_dropped", 64'(busy), 64'd0);
        check("timeout_mem_rd_dropped", 64'(mem_rd), 64'd0);
`else
        check("no_timeout_err", 64'(err_cycle), 64'd0);
        check("stall_still_busy", 64'(busy), 64'd1);
        check("stall_mem_rd_held", 64'(mem_rd), 64'd1);
        check("stall_mem_addr_held", 64'(mem_addr), 64'h5555);
`endif
        $display("txn stall: err_cycle=%0d busy=%0b mem_rd=%0b", err_cycle, busy, mem_rd);

        // Async reset while in RD_HI with mem_ready low
        do_reset();
        @(negedge clk);
        start = 1'b1; mode = 2'b10; addr = 16'h3000; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b1; mem_data = 8'h10;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rd_hi_addr_before_reset", 64'(mem_addr), 64'h3001);
        check("rd_hi_busy_before_reset", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_bad = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            if (cs_l_in || cs_h_in || cs_16_in || done || mem_rd) saw_bad = 1;
        end
        mem_ready = 1'b0;
        check("no_strobe_after_reset", 64'(saw_bad), 64'd0);
        $display("txn async_reset: post_reset_activity=%0b", saw_bad);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_pair_loader.md
Name: reg_pair_loader

Overview:
Sequencer that fills a double 8-bit register pair from the 8-bit memory data bus. It issues one byte read (byte modes) or two consecutive byte reads (word mode) with a ready handshake. It then drives the pair's write-side selects and data buses for exactly one cycle: low/high byte write, or a 16-bit write. It sits between the memory interface and the register file write port in the CPU datapath.

Parameters:
ADDR_W, 16, width of memory address and start address
TIMEOUT, 15, max cycles to wait for mem_ready per byte (used only with optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse, sampled in IDLE only
mode  in  2  00 byte->low, 01 byte->high, 10 word, 11 reserved (treated as word)
addr  in  ADDR_W  byte address of first (low) byte, captured on start
mem_addr  out  ADDR_W  memory read address
mem_rd  out  1  read request, held until accepted
mem_ready  in  1  read accepted; mem_data valid this cycle
mem_data  in  8  read data
cs_l_in  out  1  low-byte write select to register pair
cs_h_in  out  1  high-byte write select
cs_16_in  out  1  16-bit write select
bus_8_in  out  8  byte data to register pair
bus_16_in  out  16  word data {high,low} to register pair
busy  out  1  high from cycle after start accepted until done
done  out  1  one-cycle pulse, coincident with the commit strobe
err  out  1  one-cycle abort pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; address/data latches 0. Reset mid-transfer aborts silently with no commit strobe.
- All outputs are registered. At most one of cs_l_in/cs_h_in/cs_16_in is high in any cycle. Each is high for exactly one cycle per transfer.
- States: IDLE, RD_LO, RD_HI, COMMIT.
- IDLE: start=1 -> capture addr and mode, go RD_LO. start while not IDLE is ignored.
- RD_LO: mem_rd=1, mem_addr=captured addr. On mem_ready=1, latch mem_data as lo. Word mode -> RD_HI; byte modes -> COMMIT. mem_ready=0 -> stay, with mem_rd and mem_addr stable.
- RD_HI: mem_rd=1, mem_addr=addr+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000). On mem_ready, latch hi and go COMMIT. mem_rd is continuous across RD_LO->RD_HI; the address changes in the same cycle.
- COMMIT (one cycle): mem_rd=0; done=1; busy=0 in this cycle; return to IDLE.
  - mode 00: cs_l_in=1, bus_8_in=lo.
  - mode 01: cs_h_in=1, bus_8_in=lo.
  - word: cs_16_in=1, bus_16_in={hi,lo}.
- Data buses hold the last driven value when not selected; there is no tristate.
- Latency with mem_ready tied high: start at cycle 0 -> mem_rd at cycle 1. Byte commit at cycle 2; word commit at cycle 3. Each mem_ready wait cycle adds one.
- start in the COMMIT cycle is ignored. start in the following IDLE cycle is accepted, giving back-to-back transfers every 3 (byte) or 4 (word) cycles.
- mem_ready while mem_rd=0 is ignored.

Optional Feature:
REG_PAIR_LOADER_TIMEOUT_EN
- Defined: a 4-bit+ wait counter resets on each state entry and increments on every RD_LO/RD_HI cycle with mem_ready=0. When it reaches TIMEOUT, the block deasserts mem_rd, pulses err for one cycle, and returns to IDLE. There is no commit strobe and no done. Partial lo data is discarded.
- Undefined: no counter; the block waits indefinitely; err is constant 0.

Test Plan:
- Reset asserted in RD_HI with mem_ready low -> all outputs 0 immediately (async); after release, no cs_* pulse ever appears.
- mode=00, addr=0x1234, mem_ready=1, mem_data=0xA5 -> mem_rd high cycle 1 at 0x1234; cycle 2 cs_l_in=1, bus_8_in=0xA5, done=1.
- mode=10, addr=0xFFFF, bytes 0x11 then 0x22, ready each cycle -> mem_addr 0xFFFF then 0x0000; cycle 3 cs_16_in=1, bus_16_in=0x2211.
- mode=01, mem_ready held low 3 cycles then high with data 0x5C -> mem_rd and mem_addr stable during wait; cs_h_in=1, bus_8_in=0x5C at cycle 5.
- start re-pulsed while busy in RD_LO -> ignored; exactly one done. Back-to-back word starts -> commits 4 cycles apart.
- With REG_PAIR_LOADER_TIMEOUT_EN, TIMEOUT=15, mem_ready never high -> err pulses once after 15 wait cycles, busy drops, no cs_* or done.
